// File: rtl/main_module_alu4_if.sv
// Bit-level operand/select bus and registered result bus of the 4-bit ALU.
// The master drives operands and select; the slave (the ALU) drives results.
interface main_module_alu4_if;
    logic s0, s1;
    logic a0, a1, a2, a3;
    logic b0, b1, b2, b3;
    logic s0_as, s1_as, s2_as, s3_as;
    logic carry_as;
    logic a_gt_b, a_eq_b, a_st_b;
    logic ab_0, ab_1, ab_2, ab_3;

    modport master (
        output s0, s1, a0, a1, a2, a3, b0, b1, b2, b3,
        input  s0_as, s1_as, s2_as, s3_as, carry_as,
        input  a_gt_b, a_eq_b, a_st_b, ab_0, ab_1, ab_2, ab_3
    );

    modport slave (
        input  s0, s1, a0, a1, a2, a3, b0, b1, b2, b3,
        output s0_as, s1_as, s2_as, s3_as, carry_as,
        output a_gt_b, a_eq_b, a_st_b, ab_0, ab_1, ab_2, ab_3
    );
endinterface

// File: rtl/main_module_alu4.sv
// 4-bit registered ALU: add, subtract, unsigned compare and AND selected by {s1,s0}.
// Only the selected unit's outputs load a result; all others load zero on the same edge.
module main_module_alu4 (
    input  logic               clk,
    input  logic               rst,
    main_module_alu4_if.slave  bus
);
    logic [3:0] a, b;
    logic [1:0] sel;
    logic [3:0] en;

    assign a   = {bus.a3, bus.a2, bus.a1, bus.a0};
    assign b   = {bus.b3, bus.b2, bus.b1, bus.b0};
    assign sel = {bus.s1, bus.s0};

    // Enable decoder: en[0]=add, en[1]=sub, en[2]=compare, en[3]=AND
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign en[gi] = (sel == 2'(gi));
        end
    endgenerate

    // Shared ripple adder: s0 inverts B and supplies the +1 for subtraction
    logic [3:0] b_x;
    logic [3:0] sum;
    logic [4:0] c;
    assign c[0] = sel[0];
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fa
            assign b_x[gi]   = b[gi] ^ sel[0];
            assign sum[gi]   = a[gi] ^ b_x[gi] ^ c[gi];
            assign c[gi + 1] = (a[gi] & b_x[gi]) | (c[gi] & (a[gi] ^ b_x[gi]));
        end
    endgenerate

    // Cascaded comparator resolving from the MSB downward
    logic [4:0] gt_c, eq_c;
    logic       lt;
    assign gt_c[0] = 1'b0;
    assign eq_c[0] = 1'b1;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cmp
            assign gt_c[gi + 1] = gt_c[gi] | (eq_c[gi] & a[3 - gi] & ~b[3 - gi]);
            assign eq_c[gi + 1] = eq_c[gi] & ~(a[3 - gi] ^ b[3 - gi]);
        end
    endgenerate
    assign lt = ~gt_c[4] & ~eq_c[4];

    logic [3:0] as_d, as_q;
    logic       carry_d, carry_q;
    logic [2:0] cmp_d, cmp_q;
    logic [3:0] ab_d, ab_q;

    assign as_d    = (en[0] | en[1]) ? sum  : 4'b0000;
    assign carry_d = (en[0] | en[1]) & c[4];
    assign cmp_d   = en[2] ? {gt_c[4], eq_c[4], lt} : 3'b000;
    assign ab_d    = en[3] ? (a & b) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            as_q    <= 4'b0000;
            carry_q <= 1'b0;
            cmp_q   <= 3'b000;
            ab_q    <= 4'b0000;
        end else begin
            as_q    <= as_d;
            carry_q <= carry_d;
            cmp_q   <= cmp_d;
            ab_q    <= ab_d;
        end
    end

    assign bus.s0_as    = as_q[0];
    assign bus.s1_as    = as_q[1];
    assign bus.s2_as    = as_q[2];
    assign bus.s3_as    = as_q[3];
    assign bus.carry_as = carry_q;
    assign bus.a_gt_b   = cmp_q[2];
    assign bus.a_eq_b   = cmp_q[1];
    assign bus.a_st_b   = cmp_q[0];
    assign bus.ab_0     = ab_q[0];
    assign bus.ab_1     = ab_q[1];
    assign bus.ab_2     = ab_q[2];
    assign bus.ab_3     = ab_q[3];
endmodule

// File: tb/tb_main_module_alu4.sv
// Directed bench for the 4-bit ALU; expected vectors are {carry, s[3:0], gt, eq, st, ab[3:0]}.
module tb_main_module_alu4;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    main_module_alu4_if bus ();

    main_module_alu4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] observed();
        return {bus.carry_as, bus.s3_as, bus.s2_as, bus.s1_as, bus.s0_as,
                bus.a_gt_b, bus.a_eq_b, bus.a_st_b,
                bus.ab_3, bus.ab_2, bus.ab_1, bus.ab_0};
    endfunction

    task automatic drive(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b);
        {bus.s1, bus.s0} = sel;
        {bus.a3, bus.a2, bus.a1, bus.a0} = a;
        {bus.b3, bus.b2, bus.b1, bus.b0} = b;
    endtask

    task automatic check(input string tag, input logic [11:0] exp);
        logic [11:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        $display("check %-12s sel=%b%b obs=%b exp=%b", tag, bus.s1, bus.s0, obs, exp);
    endtask

    // Apply vector, clock once, sample 1 time unit after the edge
    task automatic step(input string tag, input logic [1:0] sel, input logic [3:0] a,
                        input logic [3:0] b, input logic [11:0] exp);
        drive(sel, a, b);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(2'b00, 4'b0000, 4'b0000);
        #2;
        check("reset", 12'b0_0000_000_0000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        step("add_5_9",    2'b00, 4'b0101, 4'b1001, 12'b0_1110_000_0000);
        step("add_9_6",    2'b00, 4'b1001, 4'b0110, 12'b0_1111_000_0000);
        step("add_3_2",    2'b00, 4'b0011, 4'b0010, 12'b0_0101_000_0000);
        step("add_11_5",   2'b00, 4'b1011, 4'b0101, 12'b1_0000_000_0000);
        step("add_15_15",  2'b00, 4'b1111, 4'b1111, 12'b1_1110_000_0000);

        step("sub_9_6",    2'b01, 4'b1001, 4'b0110, 12'b1_0011_000_0000);
        step("sub_5_9",    2'b01, 4'b0101, 4'b1001, 12'b0_1100_000_0000);
        step("sub_7_7",    2'b01, 4'b0111, 4'b0111, 12'b1_0000_000_0000);
        step("sub_0_1",    2'b01, 4'b0000, 4'b0001, 12'b0_1111_000_0000);

        step("cmp_gt",     2'b10, 4'b1010, 4'b0011, 12'b0_0000_100_0000);
        step("cmp_eq",     2'b10, 4'b0110, 4'b0110, 12'b0_0000_010_0000);
        step("cmp_st",     2'b10, 4'b0000, 4'b1111, 12'b0_0000_001_0000);
        step("cmp_lsb_gt", 2'b10, 4'b1001, 4'b1000, 12'b0_0000_100_0000);

        step("and_d_b",    2'b11, 4'b1101, 4'b1011, 12'b0_0000_000_1001);
        step("and_f_0",    2'b11, 4'b1111, 4'b0000, 12'b0_0000_000_0000);

        step("sw_add",     2'b00, 4'b1011, 4'b0101, 12'b1_0000_000_0000);
        step("sw_cmp",     2'b10, 4'b1011, 4'b0101, 12'b0_0000_100_0000);
        step("sw_and",     2'b11, 4'b1011, 4'b0101, 12'b0_0000_000_0001);
        step("sw_sub",     2'b01, 4'b1011, 4'b0101, 12'b1_0110_000_0000);

        step("pre_rst",    2'b00, 4'b1011, 4'b0101, 12'b1_0000_000_0000);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", 12'b0_0000_000_0000);
        @(posedge clk);
        #1;
        check("rst_hold1", 12'b0_0000_000_0000);
        @(posedge clk);
        #1;
        check("rst_hold2", 12'b0_0000_000_0000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release", 12'b1_0000_000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
